// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [3:0] PAT_COUNT_INIT  = 4'b0000;
  localparam logic [3:0] PAT_BOUNCE_INIT = 4'b0001;
  localparam logic [3:0] PAT_BLINK_INIT  = 4'b1111;
  localparam logic [3:0] PAT_OFF         = 4'b0000;

  // Pattern loaded when a mode is entered.
  function automatic logic [3:0] entry_pattern(input mode_e m);
    logic [3:0] p;
    case (m)
      MODE_COUNT:  p = PAT_COUNT_INIT;
      MODE_BOUNCE: p = PAT_BOUNCE_INIT;
      MODE_BLINK:  p = PAT_BLINK_INIT;
      default:     p = PAT_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_debounce.sv
// Button conditioning: 2-FF synchronizer followed by a stability counter.
// The output level only follows the synchronized input after it has been
// stable for DEB_CYCLES consecutive cycles. Used with LEDSEQ_DEBOUNCE_EN.
module led_btn_debounce
  import led_seq_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_TERM = DW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [DW-1:0] stab_q,  stab_d;
  logic          level_q, level_d;

  // Next-state: synchronizer shift and stability counting toward a level change.
  always_comb begin
    sync1_d = i_raw;
    sync2_d = sync1_q;
    stab_d  = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (stab_q == DEB_TERM) begin
        level_d = sync2_q;
      end else begin
        stab_d = stab_q + 1'b1;
      end
    end
  end

  // Register all debouncer state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      stab_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      stab_q  <= stab_d;
      level_q <= level_d;
    end
  end

  assign o_level = level_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: step prescaler, button-advanced mode FSM, pause.
// Optional macro LEDSEQ_DEBOUNCE_EN inserts led_btn_debounce on i_btn_mode.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 30000000,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_btn_mode,
  input  logic       i_pause,
  output logic       o_led1,
  output logic       o_led2,
  output logic       o_led3,
  output logic       o_led4,
  output logic [1:0] o_mode,
  output logic       o_tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TICK_DIV - 1);

  logic btn_lvl;

`ifdef LEDSEQ_DEBOUNCE_EN
  led_btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_raw  (i_btn_mode),
    .o_level(btn_lvl)
  );
`else
  // DEB_CYCLES only matters with the debouncer; referenced here so the
  // parameter list is identical in both builds.
  if (DEB_CYCLES == 0) begin : g_deb_cfg_ignored
  end
  assign btn_lvl = i_btn_mode;
`endif

  logic [CNT_W-1:0] cnt_q,  cnt_d;
  mode_e            mode_q, mode_d;
  logic [3:0]       pat_q,  pat_d;
  dir_e             dir_q,  dir_d;
  logic             tick_q, tick_d;
  logic             btn_q,  btn_d;

  logic       adv;
  logic [3:0] bounce_nxt;

  assign adv = btn_lvl & ~btn_q;

  // Next one-hot position for the bounce pattern in the current direction.
  always_comb begin
    bounce_nxt = (dir_q == DIR_LEFT) ? {pat_q[2:0], 1'b0} : {1'b0, pat_q[3:1]};
    if (bounce_nxt == 4'b0000) begin
      bounce_nxt = PAT_BOUNCE_INIT;
    end
  end

  // Next-state: button advance has priority over a step; pause freezes stepping.
  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    pat_d  = pat_q;
    dir_d  = dir_q;
    tick_d = 1'b0;
    btn_d  = btn_lvl;
    if (adv) begin
      mode_d = mode_e'(mode_q + 2'd1);
      cnt_d  = '0;
      pat_d  = entry_pattern(mode_d);
      dir_d  = DIR_LEFT;
    end else if (!i_pause) begin
      if (cnt_q == CNT_TERM) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        case (mode_q)
          MODE_COUNT:  pat_d = pat_q + 4'd1;
          MODE_BOUNCE: begin
            pat_d = bounce_nxt;
            if (bounce_nxt == 4'b1000) dir_d = DIR_RIGHT;
            if (bounce_nxt == 4'b0001) dir_d = DIR_LEFT;
          end
          MODE_BLINK:  pat_d = ~pat_q;
          default:     pat_d = PAT_OFF;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Register prescaler, mode FSM, pattern and outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mode_q <= MODE_COUNT;
      pat_q  <= PAT_COUNT_INIT;
      dir_q  <= DIR_LEFT;
      tick_q <= 1'b0;
      btn_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      pat_q  <= pat_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
      btn_q  <= btn_d;
    end
  end

  assign o_led1 = pat_q[0];
  assign o_led2 = pat_q[1];
  assign o_led3 = pat_q[2];
  assign o_led4 = pat_q[3];
  assign o_mode = mode_q;
  assign o_tick = tick_q;

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Controller that sequences the four board LEDs through selectable display patterns at a programmable step rate. It owns the step prescaler, a mode state machine advanced by a push-button request, and a pause control. It sits between the board clock/button pins and the LED pins, replacing a free-running binary LED count with mode-sequenced patterns.

Parameters:
TICK_DIV, 30000000, clock cycles per pattern step; legal range >= 2.
CNT_W, $clog2(TICK_DIV), prescaler width; derived, not overridden.
DEB_CYCLES, 1000000, button stable-time in cycles; used only when LEDSEQ_DEBOUNCE_EN is defined.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  synchronous, active-low reset.
i_btn_mode  input  1  mode-advance request; rising edge advances mode.
i_pause  input  1  level; high freezes prescaler and pattern.
o_led1  output  1  pattern bit 0.
o_led2  output  1  pattern bit 1.
o_led3  output  1  pattern bit 2.
o_led4  output  1  pattern bit 3.
o_mode  output  2  current mode: 0 COUNT, 1 BOUNCE, 2 BLINK, 3 OFF.
o_tick  output  1  one-cycle strobe, high in the cycle the pattern steps.

Behaviour:
- Reset (rst_n low at posedge): prescaler=0, mode=COUNT, pattern=4'b0000, bounce dir=left, o_tick=0, edge-detect history=0. All outputs are registered.
- Prescaler: counts 0..TICK_DIV-1. Internal step = (cnt==TICK_DIV-1) && !i_pause && !adv. On that edge: cnt<=0, o_tick<=1, pattern<=next(pattern). Otherwise o_tick<=0. Unpaused step period is exactly TICK_DIV cycles. LEDs and o_tick change on the same edge.
- Pause: while i_pause=1, cnt and pattern hold and o_tick=0. On release, counting resumes from the held cnt value, with no restart.
- Next pattern per mode:
  - COUNT: pattern+1 mod 16 (4'b1111 -> 4'b0000).
  - BOUNCE: one-hot ping-pong 0001,0010,0100,1000,0100,0010,0001,... Direction flips when 1000 (to right) or 0001 (to left) is reached. Cycle length is 6 steps.
  - BLINK: toggles 1111 <-> 0000.
  - OFF: holds 0000.
- Mode advance (adv): rising edge of the button signal, detected as (btn && !btn_q).
  - Without debounce, the mode updates on the same edge at which 1 is first sampled after 0.
  - On adv: mode<=mode+1 (OFF wraps to COUNT), cnt<=0, o_tick<=0, and pattern is loaded with the entry value: COUNT 0000; BOUNCE 0001 with dir=left; BLINK 1111; OFF 0000.
- Simultaneous adv and terminal count: adv wins and the step is dropped.
- adv while paused: the mode changes and the entry pattern loads; the block stays frozen.
- A button held high produces exactly one advance.
- Reset mid-step or mid-debounce: everything returns to reset values on that edge, with no stray o_tick.

Optional Feature:
LEDSEQ_DEBOUNCE_EN:
- Defined: i_btn_mode is treated as a raw asynchronous pin. It passes through a 2-FF synchronizer, then a debouncer that updates its output only after the synchronized input has been stable for DEB_CYCLES consecutive cycles. Edge detection runs on the debounced level. Latency from a clean press to the mode change is 2+DEB_CYCLES+1 cycles. Glitches shorter than DEB_CYCLES are ignored.
- Undefined: i_btn_mode is a synchronous, clean input, edge-detected directly with no synchronizer. DEB_CYCLES is unused.

Decomposition:
- Package led_seq_pkg: mode enum (MODE_COUNT/BOUNCE/BLINK/OFF, 2 bits); entry-pattern constants PAT_COUNT_INIT=4'b0000, PAT_BOUNCE_INIT=4'b0001, PAT_BLINK_INIT=4'b1111, PAT_OFF=4'b0000.
- Sub-module led_btn_debounce (synchronizer plus stability counter), instantiated only under LEDSEQ_DEBOUNCE_EN.
- Prescaler, mode FSM and pattern logic remain in the top module.

Test Plan:
- TICK_DIV=4: reset, then run 80 cycles. o_tick pulses every 4 cycles; LEDs step 0000->0001->...->1111->0000 after 16 ticks.
- Pulse i_btn_mode once. o_mode becomes 1 and LEDs=0001 on that edge. Subsequent ticks give 0010,0100,1000,0100,0010,0001.
- Hold i_btn_mode high 20 cycles from BOUNCE. Exactly one advance to BLINK (LEDs 1111), toggling to 0000 on the next tick. Four presses from COUNT return o_mode to 0.
- Assert i_pause for 10 cycles mid-count at cnt=2. No o_tick and LEDs hold. After release, the next tick arrives exactly 2 cycles later.
- Button edge coincident with cnt==TICK_DIV-1. Mode advances, no o_tick, and the next tick is 4 cycles later. Drop rst_n mid-pattern: LEDs=0000, o_mode=0, o_tick=0 on the next edge.
- With LEDSEQ_DEBOUNCE_EN and DEB_CYCLES=8: a 5-cycle glitch causes no change. A 20-cycle press advances the mode 11 cycles after the rising edge.
